// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types for the shared-register arbiter: FSM state encoding and the
// upper bound on the requester count.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    localparam int MAX_NREQ = 8;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set req bit at or after
// ptr, wrapping modulo NREQ. With ptr tied to 0 it is a plain lowest-index
// priority encoder.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int SELW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            valid,
    output logic [SELW-1:0] index
);

    // Scan from the farthest candidate back to ptr so the nearest set bit wins.
    always_comb begin
        int pos;
        logic [SELW-1:0] idx;
        valid = 1'b0;
        index = '0;
        pos   = 0;
        idx   = '0;
        for (int i = MAX_NREQ - 1; i >= 0; i--) begin
            if (i < NREQ) begin
                pos = int'(ptr) + i;
                if (pos >= NREQ) begin
                    pos = pos - NREQ;
                end
                idx = pos[SELW-1:0];
                if (req[idx]) begin
                    valid = 1'b1;
                    index = idx;
                end
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter/sequencer sharing one write-enabled datapath register
// among NREQ requesters. Each transaction: GRANT -> WRITE (reg_en pulse) ->
// ACK (one-cycle ack to the owner) -> IDLE.
// Build option: define ARB_FIXED_PRIORITY_EN for fixed priority, where the
// lowest set req index always wins and no rotating pointer is kept.
//
// Handshake: a requester raises req[i] and holds it until ack[i] pulses for
// one cycle; it must drop req[i] within one cycle of that ack. Dropping
// req[i] while only granted (before the write cycle) abandons the request
// without a write or an ack; dropping it during the write cycle is ignored.
module shared_reg_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    localparam int SELW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [SELW-1:0]       reg_sel,
    output logic [WIDTH-1:0]      reg_wdata,
    output logic                  reg_en,
    output logic                  busy
);

    arb_state_t      state;
    logic [SELW-1:0] owner;
    logic [SELW-1:0] pick_ptr;
    logic            pick_valid;
    logic [SELW-1:0] pick_index;

`ifdef ARB_FIXED_PRIORITY_EN
    assign pick_ptr = '0;
`else
    logic [SELW-1:0] ptr;
    assign pick_ptr = ptr;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .SELW (SELW)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .index (pick_index)
    );

    // Transaction sequencer: latches the winner in IDLE and walks it through
    // grant, write and ack; the owner is kept after ACK so the mux holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            ptr   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_index;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (req[owner]) begin
                        state <= WRITE;
                    end else begin
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    state <= ACK;
                end
                ACK: begin
`ifndef ARB_FIXED_PRIORITY_EN
                    if (owner == SELW'(NREQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= owner + SELW'(1);
                    end
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore output decode from the registered state and owner.
    always_comb begin
        gnt    = '0;
        ack    = '0;
        reg_en = 1'b0;
        busy   = (state != IDLE);
        case (state)
            GRANT: gnt = NREQ'(1) << owner;
            WRITE: begin
                gnt    = NREQ'(1) << owner;
                reg_en = 1'b1;
            end
            ACK:   ack = NREQ'(1) << owner;
            default: ;
        endcase
    end

    assign reg_sel   = owner;
    assign reg_wdata = wdata[int'(owner)*WIDTH +: WIDTH];

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (NREQ=4, WIDTH=32). Models the shared
// register externally and checks grant order, timing, abort and reset paths.
module tb_shared_reg_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int SELW  = 2;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [SELW-1:0]       reg_sel;
    logic [WIDTH-1:0]      reg_wdata;
    logic                  reg_en;
    logic                  busy;

    logic [WIDTH-1:0] wv [NREQ];
    logic [WIDTH-1:0] shared_reg;
    int               n_checks;
    int               n_errors;

    shared_reg_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .wdata     (wdata),
        .gnt       (gnt),
        .ack       (ack),
        .reg_sel   (reg_sel),
        .reg_wdata (reg_wdata),
        .reg_en    (reg_en),
        .busy      (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign wdata = {wv[3], wv[2], wv[1], wv[0]};

    // The shared datapath register the arbiter drives; not cleared by the
    // arbiter reset, so a completed write survives it.
    initial shared_reg = '0;
    always @(posedge clk) begin
        if (reg_en) shared_reg <= reg_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gnt and ack must never be multi-hot once out of reset
    always @(negedge clk) begin
        if (!reset) begin
            check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            check("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
        end
    end

    // Full transaction, started while the DUT is in IDLE.
    task automatic txn(input logic [NREQ-1:0] mask, input int own, input bit hold);
        logic [NREQ-1:0] oh;
        oh  = NREQ'(1) << own;
        req = mask;
        tick();
        check("grant_gnt", 32'(gnt), 32'(oh));
        check("grant_busy", 32'(busy), 32'd1);
        check("grant_en", 32'(reg_en), 32'd0);
        check("grant_ack", 32'(ack), 32'd0);
        tick();
        check("write_en", 32'(reg_en), 32'd1);
        check("write_gnt", 32'(gnt), 32'(oh));
        check("write_sel", 32'(reg_sel), 32'(own));
        check("write_data", reg_wdata, wv[own]);
        tick();
        check("ack_ack", 32'(ack), 32'(oh));
        check("ack_gnt", 32'(gnt), 32'd0);
        check("ack_en", 32'(reg_en), 32'd0);
        check("ack_reg", shared_reg, wv[own]);
        req = hold ? mask : (mask & ~oh);
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ack", 32'(ack), 32'd0);
        check("idle_sel", 32'(reg_sel), 32'(own));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_en", 32'(reg_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel", 32'(reg_sel), 32'd0);
        check("rst_wdata", reg_wdata, wv[0]);
        reset = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        req      = '0;
        wv[0]    = 32'h1111_1111;
        wv[1]    = 32'hDEAD_BEEF;
        wv[2]    = 32'h2222_2222;
        wv[3]    = 32'h3333_3333;

        do_reset();

`ifndef ARB_FIXED_PRIORITY_EN
        // single request from requester 1; pointer moves to 2
        txn(4'b0010, 1, 1'b0);

        // abort: requester 2 drops req in its GRANT cycle
        req = 4'b0100;
        tick();
        check("abort_gnt", 32'(gnt), 32'b0100);
        req = 4'b0000;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_en", 32'(reg_en), 32'd0);
        check("abort_gnt_clr", 32'(gnt), 32'd0);
        tick();
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_reg", shared_reg, 32'hDEAD_BEEF);

        // pointer still 2: requester 2 wins over 1
        txn(4'b0110, 2, 1'b0);
        // pointer 3, only 0 requesting: wrap and skip
        txn(4'b0001, 0, 1'b0);
        // pointer now 1: requester 2 beats 0
        txn(4'b0101, 2, 1'b0);

        // reset asserted during the write cycle
        req = 4'b1000;
        tick();
        check("rw_gnt", 32'(gnt), 32'b1000);
        tick();
        check("rw_en", 32'(reg_en), 32'd1);
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        check("rw_gnt0", 32'(gnt), 32'd0);
        check("rw_ack0", 32'(ack), 32'd0);
        check("rw_en0", 32'(reg_en), 32'd0);
        check("rw_busy0", 32'(busy), 32'd0);
        check("rw_sel0", 32'(reg_sel), 32'd0);
        check("rw_reg_kept", shared_reg, 32'h3333_3333);
        reset = 1'b0;
        tick();
        check("rw_no_ack", 32'(ack), 32'd0);
        check("rw_idle", 32'(busy), 32'd0);

        // everyone requesting from pointer 0: order 0,1,2,3,0
        txn(4'b1111, 0, 1'b0);
        txn(4'b1111, 1, 1'b0);
        txn(4'b1111, 2, 1'b0);
        txn(4'b1111, 3, 1'b0);
        txn(4'b1111, 0, 1'b0);
`else
        // fixed priority: requester 1 always wins, 3 starves while 1 holds
        txn(4'b1010, 1, 1'b1);
        txn(4'b1010, 1, 1'b1);
        txn(4'b1010, 1, 1'b1);
        txn(4'b1000, 3, 1'b0);
        txn(4'b1001, 0, 1'b0);
`endif

        req = '0;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one enabled, resettable datapath register (WIDTH bits, synchronous reset, write-enable) among NREQ requesters.
- Decides which requester owns the register and drives the operand-select mux.
- Pulses the register's write enable for exactly one cycle per transaction, then returns an ack to the owner.
- Sits between the peripheral requesters and the shared register/mux in the FPGA top level; runs on the on-chip low-speed oscillator clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, data width of the shared register.
- SELW, $clog2(NREQ), width of the owner index (derived; not overridden).

Ports:
- clk  input  1  system clock (low-speed oscillator).
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; held high until the matching ack.
- wdata  input  NREQ*WIDTH  requester write data, flattened; slice i = bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  one-hot grant; at most one bit set.
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- reg_sel  output  SELW  index of the current owner; drives the operand mux select.
- reg_wdata  output  WIDTH  wdata slice of the owner; feeds the shared register D input.
- reg_en  output  1  write enable to the shared register.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values:
  - state = IDLE; gnt = 0; ack = 0; reg_en = 0; busy = 0.
  - reg_sel = 0; reg_wdata = wdata slice 0 (combinational from reg_sel).
  - Round-robin pointer ptr = 0.
- Reset mid-transaction: abandons the transaction; no ack is issued. A write already clocked in is not undone.
- FSM (Moore; outputs decoded from registered state and owner):
  - IDLE: if any req, pick the winner = first set req at or after ptr, wrapping modulo NREQ. Latch owner; next state GRANT. Otherwise stay in IDLE.
  - GRANT: gnt[owner] = 1. If req[owner] is still high, go to WRITE. If it dropped, abort to IDLE: no write, no ack, ptr unchanged.
  - WRITE: gnt[owner] = 1 and reg_en = 1. The register captures reg_wdata at the end of this cycle. Next state ACK unconditionally; a req drop here is ignored.
  - ACK: ack[owner] = 1; gnt = 0. ptr <= (owner+1) mod NREQ. Next state IDLE.
- Latency: req rises with IDLE in cycle n -> gnt in n+1 -> reg_en in n+2 -> ack in n+3 -> IDLE in n+4.
- Throughput: earliest next grant is n+5, so one write per 4 cycles under continuous load.
- Requests that arrive while busy are not lost; they are evaluated in the next IDLE cycle.
- A requester must drop req within one cycle of its ack. If req is still high in IDLE, it is treated as a new request, and round-robin gives the others priority first.
- reg_sel holds the last owner while in IDLE, so the mux output stays stable.
- Pointer wrap: owner NREQ-1 sets ptr to 0.
- Selection: only req bits with index < NREQ are considered.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: winner is the lowest-index set req; ptr is not implemented; all other behaviour is identical.
- Undefined (default): round-robin as above.

Decomposition:
- Package arb_pkg:
  - state enum arb_state_t {IDLE, GRANT, WRITE, ACK}, 2 bits.
  - localparam MAX_NREQ = 8.
- Sub-module rr_pick: combinational rotate/priority/unrotate. Inputs req and ptr; outputs valid and index. Under ARB_FIXED_PRIORITY_EN it is used with ptr tied to 0.

Test Plan:
- Reset then single request: req=4'b0010, wdata[1]=32'hDEADBEEF -> gnt=0010 in cycle 1, reg_en=1 with reg_sel=1 and reg_wdata=DEADBEEF in cycle 2, ack=0010 in cycle 3, register reads DEADBEEF; ptr=2.
- All requesting: req=4'b1111 held, each dropped one cycle after its own ack and re-raised -> grant order 0,1,2,3,0; each grant 4 cycles apart; gnt is never multi-hot.
- Abort: req=4'b0100 raised, dropped in the GRANT cycle -> reg_en never asserts, no ack, register unchanged, ptr unchanged, back in IDLE next cycle.
- Wrap and skip: ptr=3, req=4'b0001 -> requester 0 granted; ptr becomes 1.
- Reset in WRITE: assert reset during the reg_en cycle -> next cycle all outputs 0, state IDLE, no ack pulse.
- With ARB_FIXED_PRIORITY_EN: req=4'b1010 held continuously -> requester 1 is always granted, requester 3 starves; verifies the macro path.
